// File: rtl/mprj_checkbit_monitor.sv
// Checkpoint monitor for the 16-bit checkbits pad field: synchronizes, debounces and
// tracks the START_CODE -> END_CODE sequence with sticky pass/fail/timeout flags and an IRQ pulse.
module mprj_checkbit_monitor #(
  parameter logic [15:0]       START_CODE = 16'hAB60,
  parameter logic [15:0]       END_CODE   = 16'hAB6A,
  parameter int unsigned       STABLE_CYC = 4,
  parameter int unsigned       TOUT_W     = 24,
  parameter logic [TOUT_W-1:0] TOUT_CYC   = TOUT_W'(30000)
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] chk_io_i,
  input  logic        cfg_enable,
  input  logic        cfg_clear,
  output logic        mon_started,
  output logic        mon_pass,
  output logic        mon_fail,
  output logic        mon_timeout,
  output logic [15:0] mon_last_code,
  output logic [3:0]  mon_step,
  output logic        mon_irq
);

  localparam int unsigned       STAB_W    = $clog2(STABLE_CYC + 1);
  localparam logic [STAB_W-1:0] STAB_TGT  = STAB_W'(STABLE_CYC);
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_CYC - TOUT_W'(1);
  localparam logic [TOUT_W-1:0] TOUT_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    PASS  = 3'd2,
    FAIL  = 3'd3,
    TOUT  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         s1_q, s1_d, s2_q, s2_d;
  logic [STAB_W-1:0]   stab_q, stab_d;
  logic [TOUT_W-1:0]   tout_q, tout_d;
  logic [15:0]         last_q, last_d;
  logic [3:0]          step_q, step_d;
  logic                started_q, started_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic                timeout_q, timeout_d;
  logic                irq_q, irq_d;
  logic                acc_stb_c;

  // A word is accepted once when it has been stable STABLE_CYC samples and differs from the last one
  assign acc_stb_c = (stab_q == STAB_TGT) && (s2_q != last_q);

  always_comb begin
    state_d   = state_q;
    s1_d      = chk_io_i;
    s2_d      = s1_q;
    stab_d    = STAB_W'(1);
    tout_d    = '0;
    last_d    = last_q;
    step_d    = step_q;
    started_d = started_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    irq_d     = 1'b0;

    // Stability counter saturates at the target so it cannot wrap back into a new accept
    if (s1_q == s2_q) begin
      stab_d = (stab_q == STAB_TGT) ? stab_q : stab_q + STAB_W'(1);
    end

    if (acc_stb_c) begin
      last_d = s2_q;
    end

    if (state_q == ARMED) begin
      tout_d = (tout_q == TOUT_MAX) ? tout_q : tout_q + TOUT_W'(1);
    end

    if (cfg_clear) begin
      state_d   = IDLE;
      tout_d    = '0;
      step_d    = '0;
      started_d = 1'b0;
      pass_d    = 1'b0;
      fail_d    = 1'b0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc_stb_c && (s2_q == START_CODE)) begin
            state_d   = ARMED;
            started_d = 1'b1;
            step_d    = START_CODE[3:0];
            tout_d    = '0;
          end
        end
        ARMED: begin
          if (acc_stb_c) begin
            tout_d = '0;
            if (s2_q == END_CODE) begin
              state_d = PASS;
              pass_d  = 1'b1;
              step_d  = END_CODE[3:0];
              irq_d   = 1'b1;
            end else if ((s2_q[15:4] == START_CODE[15:4]) && (s2_q[3:0] > step_q)) begin
              step_d = s2_q[3:0];
            end else begin
              state_d = FAIL;
              fail_d  = 1'b1;
              irq_d   = 1'b1;
            end
          end else if (tout_q == TOUT_LAST) begin
            state_d   = TOUT;
            timeout_d = 1'b1;
            irq_d     = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Disable wipes everything, including sync and debounce history
    if (!cfg_enable) begin
      state_d   = IDLE;
      s1_d      = '0;
      s2_d      = '0;
      stab_d    = '0;
      tout_d    = '0;
      last_d    = '0;
      step_d    = '0;
      started_d = 1'b0;
      pass_d    = 1'b0;
      fail_d    = 1'b0;
      timeout_d = 1'b0;
      irq_d     = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      s1_q      <= '0;
      s2_q      <= '0;
      stab_q    <= '0;
      tout_q    <= '0;
      last_q    <= '0;
      step_q    <= '0;
      started_q <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      stab_q    <= stab_d;
      tout_q    <= tout_d;
      last_q    <= last_d;
      step_q    <= step_d;
      started_q <= started_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
      irq_q     <= irq_d;
    end
  end

  assign mon_started   = started_q;
  assign mon_pass      = pass_q;
  assign mon_fail      = fail_q;
  assign mon_timeout   = timeout_q;
  assign mon_last_code = last_q;
  assign mon_step      = step_q;
  assign mon_irq       = irq_q;

endmodule

// File: tb/tb_mprj_checkbit_monitor.sv
// Directed bench for mprj_checkbit_monitor: a vector table of held pad words with
// hand-computed flags, plus a hand-written timeout sequence (TOUT_CYC overridden to 100).
module tb_mprj_checkbit_monitor;

  logic        clk;
  logic        rst;
  logic [15:0] chk;
  logic        en;
  logic        clr;
  logic        started, pass, fail, tout, irq;
  logic [15:0] last;
  logic [3:0]  step;

  int n_cmp = 0;
  int n_err = 0;
  int irq_cnt = 0;
  logic saw_ffff = 1'b0;

  mprj_checkbit_monitor #(
    .START_CODE (16'hAB60),
    .END_CODE   (16'hAB6A),
    .STABLE_CYC (4),
    .TOUT_W     (24),
    .TOUT_CYC   (24'd100)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .chk_io_i      (chk),
    .cfg_enable    (en),
    .cfg_clear     (clr),
    .mon_started   (started),
    .mon_pass      (pass),
    .mon_fail      (fail),
    .mon_timeout   (tout),
    .mon_last_code (last),
    .mon_step      (step),
    .mon_irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // IRQ pulses and glitch leakage are observed on the falling edge
  always @(negedge clk) begin
    if (irq) irq_cnt++;
    if (last == 16'hFFFF) saw_ffff = 1'b1;
  end

  typedef struct {
    logic        rst;
    logic        en;
    logic        clr;
    logic [15:0] chk;
    int          cyc;
    logic        started;
    logic        pass;
    logic        fail;
    logic        tout;
    logic [15:0] last;
    logic [3:0]  step;
    logic        chk_step;
    int          irqs;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic e, input logic c, input logic [15:0] w,
                              input int cyc, input logic st, input logic p, input logic f,
                              input logic t, input logic [15:0] lc, input logic [3:0] sp,
                              input logic cs, input int ni);
    vec_t v;
    v.rst = r; v.en = e; v.clr = c; v.chk = w; v.cyc = cyc;
    v.started = st; v.pass = p; v.fail = f; v.tout = t;
    v.last = lc; v.step = sp; v.chk_step = cs; v.irqs = ni;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    rst = 1'b1; en = 1'b1; clr = 1'b0; chk = 16'h0000;

    // rst en clr word cyc | started pass fail tout last step chk_step irqs
    // basic sequence with a skipped step
    add(1, 1, 0, 16'h0000, 2,  0, 0, 0, 0, 16'h0000, 4'h0, 1, 0);
    add(0, 1, 0, 16'hAB60, 10, 1, 0, 0, 0, 16'hAB60, 4'h0, 1, 0);
    add(0, 1, 0, 16'hAB62, 10, 1, 0, 0, 0, 16'hAB62, 4'h2, 1, 0);
    add(0, 1, 0, 16'hAB6A, 10, 1, 1, 0, 0, 16'hAB6A, 4'h0, 0, 1);
    // clear keeps sync state, so the word on the pads is not re-accepted; then glitch rejection
    add(0, 1, 1, 16'hAB6A, 1,  0, 0, 0, 0, 16'hAB6A, 4'h0, 1, 0);
    add(0, 1, 0, 16'hAB6A, 8,  0, 0, 0, 0, 16'hAB6A, 4'h0, 1, 0);
    add(0, 1, 0, 16'hAB60, 10, 1, 0, 0, 0, 16'hAB60, 4'h0, 1, 0);
    add(0, 1, 0, 16'hFFFF, 3,  1, 0, 0, 0, 16'hAB60, 4'h0, 1, 0);
    add(0, 1, 0, 16'hAB6A, 10, 1, 1, 0, 0, 16'hAB6A, 4'h0, 0, 1);
    // backwards step fails; later END_CODE is ignored
    add(0, 1, 1, 16'hAB6A, 1,  0, 0, 0, 0, 16'hAB6A, 4'h0, 1, 0);
    add(0, 1, 0, 16'hAB60, 10, 1, 0, 0, 0, 16'hAB60, 4'h0, 1, 0);
    add(0, 1, 0, 16'hAB65, 10, 1, 0, 0, 0, 16'hAB65, 4'h5, 1, 0);
    add(0, 1, 0, 16'hAB63, 10, 1, 0, 1, 0, 16'hAB63, 4'h5, 1, 1);
    add(0, 1, 0, 16'hAB6A, 10, 1, 0, 1, 0, 16'hAB6A, 4'h5, 1, 0);
    // words before START_CODE are ignored in IDLE
    add(1, 1, 0, 16'h0000, 2,  0, 0, 0, 0, 16'h0000, 4'h0, 1, 0);
    add(0, 1, 0, 16'h1234, 10, 0, 0, 0, 0, 16'h1234, 4'h0, 1, 0);
    add(0, 1, 0, 16'hAB6A, 10, 0, 0, 0, 0, 16'hAB6A, 4'h0, 1, 0);
    add(0, 1, 0, 16'hAB60, 10, 1, 0, 0, 0, 16'hAB60, 4'h0, 1, 0);
    add(0, 1, 0, 16'hAB6A, 10, 1, 1, 0, 0, 16'hAB6A, 4'h0, 0, 1);
    // disable clears everything including sync history, so the same word is accepted again
    add(0, 0, 0, 16'hAB6A, 2,  0, 0, 0, 0, 16'h0000, 4'h0, 1, 0);
    add(0, 1, 0, 16'hAB60, 10, 1, 0, 0, 0, 16'hAB60, 4'h0, 1, 0);
    add(0, 0, 0, 16'hAB60, 2,  0, 0, 0, 0, 16'h0000, 4'h0, 1, 0);
    // reset mid-sequence, then clear coincident with the AB60 accept
    add(0, 1, 0, 16'hAB60, 10, 1, 0, 0, 0, 16'hAB60, 4'h0, 1, 0);
    add(0, 1, 0, 16'hAB63, 10, 1, 0, 0, 0, 16'hAB63, 4'h3, 1, 0);
    add(1, 1, 0, 16'hAB63, 1,  0, 0, 0, 0, 16'h0000, 4'h0, 1, 0);
    add(0, 1, 0, 16'hAB63, 10, 0, 0, 0, 0, 16'hAB63, 4'h0, 1, 0);
    add(0, 1, 0, 16'hAB60, 5,  0, 0, 0, 0, 16'hAB63, 4'h0, 1, 0);
    add(0, 1, 1, 16'hAB60, 1,  0, 0, 0, 0, 16'hAB60, 4'h0, 1, 0);
    add(0, 1, 0, 16'hAB60, 8,  0, 0, 0, 0, 16'hAB60, 4'h0, 1, 0);
    add(0, 1, 0, 16'hAB6A, 10, 0, 0, 0, 0, 16'hAB6A, 4'h0, 1, 0);

    tick();
    foreach (vecs[i]) begin
      rst = vecs[i].rst; en = vecs[i].en; clr = vecs[i].clr; chk = vecs[i].chk;
      irq_cnt = 0;
      repeat (vecs[i].cyc) tick();
      check($sformatf("v%0d started", i), 16'(started), 16'(vecs[i].started));
      check($sformatf("v%0d pass", i),    16'(pass),    16'(vecs[i].pass));
      check($sformatf("v%0d fail", i),    16'(fail),    16'(vecs[i].fail));
      check($sformatf("v%0d timeout", i), 16'(tout),    16'(vecs[i].tout));
      check($sformatf("v%0d last", i),    last,         vecs[i].last);
      if (vecs[i].chk_step) check($sformatf("v%0d step", i), 16'(step), 16'(vecs[i].step));
      check($sformatf("v%0d irqs", i),    16'(irq_cnt), 16'(vecs[i].irqs));
    end
    check("glitch never accepted", 16'(saw_ffff), 16'h0000);

    // Timeout: flag must rise exactly 100 cycles after START_CODE acceptance
    rst = 1'b1; en = 1'b1; clr = 1'b0; chk = 16'h0000;
    repeat (2) tick();
    rst = 1'b0; chk = 16'hAB60;
    k = 0;
    while (!started && k < 50) begin
      tick();
      k++;
    end
    check("tout start latency", 16'(k), 16'd6);
    irq_cnt = 0;
    k = 0;
    while (!tout && k < 300) begin
      tick();
      k++;
      if (k == 99) check("tout not early", 16'(tout), 16'h0000);
    end
    check("tout cycles", 16'(k), 16'd100);
    repeat (3) tick();
    check("tout irqs", 16'(irq_cnt), 16'd1);
    check("tout fail", 16'(fail), 16'h0000);
    chk = 16'hAB6A;
    repeat (10) tick();
    check("tout terminal pass", 16'(pass), 16'h0000);
    check("tout terminal flag", 16'(tout), 16'h0001);
    check("tout terminal last", last, 16'hAB6A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
